ysyx_22040729_core_sequencer: RTL and testbench
===============================================

YSYX_22040729_CORE_SEQUENCER -- requirements
Module: ysyx_22040729_core_sequencer

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
  DATA_WIDTH  64   width of the cycle/instret counters
  TIMEOUT     255  maximum bus wait cycles before error; range 1..255
REQ-002 SHALL have one clock and an asynchronous, active-low reset, and these ports (name  direction  width  meaning):
  clk           in   1   sole clock, rising edge
  rst_n         in   1   asynchronous active-low reset
  imem_req      out  1   instruction fetch request
  imem_valid    in   1   fetch data valid, same-cycle accept
  ir_we         out  1   latch instruction register
  dec_rf_we     in   1   decoder: writes register file
  dec_mem_wen   in   1   decoder: store
  dec_load      in   1   decoder: load (rf_wdata_src==3'b001)
  dec_csr       in   1   decoder: SYSTEM-type instruction
  dec_ecall     in   1   decoder: ecall
  dec_mret      in   1   decoder: mret
  dec_ebreak    in   1   decoder: ebreak (simulation halt)
  dmem_req      out  1   data memory request
  dmem_we       out  1   data memory write qualifier
  dmem_ack      in   1   data memory done, same-cycle accept
  pc_we         out  1   commit next PC
  rf_we         out  1   commit register write
  csr_commit    out  1   commit CSR side effects
  trap_take     out  1   ecall trap entry
  trap_ret      out  1   mret return
  halted        out  1   ebreak reached, sticky
  bus_err       out  1   bus timeout, sticky
  state         out  3   current FSM state (debug)
  cycle_cnt     out  DATA_WIDTH  cycles since reset
  instret_cnt   out  DATA_WIDTH  retired instructions

Function
REQ-003 FSM states and encodings SHALL be: BOOT=0, FETCH=1, DECODE=2, MEM=3, WB=4, HALT=5, ERROR=6.
REQ-004 BOOT SHALL go to FETCH unconditionally on the first clock edge after reset release.
REQ-005 FETCH: imem_req=1; on imem_valid=1 SHALL pulse ir_we in that cycle and go to DECODE; otherwise stay.
REQ-006 DECODE: one cycle, no outputs asserted; next state SHALL be HALT if dec_ebreak, else MEM if dec_load|dec_mem_wen, else WB.
REQ-007 MEM: dmem_req=1, dmem_we=dec_mem_wen, both held stable until dmem_ack=1; then go to WB.
REQ-008 WB: exactly one cycle; pc_we=1; rf_we=dec_rf_we&~dec_mem_wen; csr_commit=dec_csr; trap_take=dec_ecall; trap_ret=dec_mret&~dec_ecall; then go to FETCH.
REQ-009 pc_we, rf_we, csr_commit, trap_take, trap_ret, ir_we SHALL be single-cycle pulses and SHALL be 0 in all other states.
REQ-010 Decoder inputs SHALL be sampled only in DECODE/MEM/WB; the sequencer holds ir_we low there so they stay stable.
REQ-011 Wait counter (8 bit): clears on entry to FETCH or MEM; increments each cycle waiting without handshake; at count==TIMEOUT without handshake SHALL go to ERROR.
REQ-012 A handshake in the same cycle the count reaches TIMEOUT SHALL win: no error.
REQ-013 HALT and ERROR SHALL be terminal until reset; halted=1 in HALT, bus_err=1 in ERROR; no requests issued.
REQ-014 cycle_cnt SHALL increment every cycle out of reset, including HALT/ERROR, and wrap modulo 2^DATA_WIDTH.
REQ-015 instret_cnt SHALL increment by 1 at each WB cycle and wrap modulo 2^DATA_WIDTH.
REQ-016 All outputs except state SHALL be registered or decoded purely from state plus the listed inputs; no combinational path from dmem_ack/imem_valid to state.

Reset
REQ-017 rst_n=0 SHALL immediately force state=BOOT, all requests and pulses 0, halted=0, bus_err=0, counters 0, wait counter 0.
REQ-018 Reset asserted mid-FETCH or mid-MEM SHALL drop imem_req/dmem_req in the same cycle, asynchronously; no partial commit.

Verification
REQ-019 Add-type, imem_valid 2 cycles after request -> FETCH 3 cycles, DECODE, WB with pc_we=1, rf_we=1; instret_cnt=1.
REQ-020 Store with dmem_ack after 4 MEM cycles -> dmem_req=dmem_we=1 for 4 cycles; WB rf_we=0, pc_we=1.
REQ-021 Load with dmem_ack same cycle as dmem_req -> MEM lasts 1 cycle; WB rf_we=1, dmem_we=0.
REQ-022 ecall then mret -> trap_take=1 in first WB, trap_ret=1 in second; csr_commit=1 in both; instret_cnt=2.
REQ-023 TIMEOUT=4, no imem_valid -> ERROR after 4 wait cycles, bus_err=1; with imem_valid on 4th cycle -> DECODE, bus_err=0.
REQ-024 ebreak -> HALT after DECODE, halted=1, no pc_we; cycle_cnt keeps counting; rst_n pulse -> BOOT, all cleared.

Source files
------------

// File: rtl/ysyx_22040729_core_sequencer.sv
// rtl/ysyx_22040729_core_sequencer.sv - multi-cycle core sequencer (fetch/decode/mem/writeback)
// Sequences a non-pipelined core: fetch handshake, decode, optional data access, single-cycle commit.
module ysyx_22040729_core_sequencer #(
  parameter int DATA_WIDTH = 64,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req,
  input  logic                  imem_valid,
  output logic                  ir_we,
  input  logic                  dec_rf_we,
  input  logic                  dec_mem_wen,
  input  logic                  dec_load,
  input  logic                  dec_csr,
  input  logic                  dec_ecall,
  input  logic                  dec_mret,
  input  logic                  dec_ebreak,
  output logic                  dmem_req,
  output logic                  dmem_we,
  input  logic                  dmem_ack,
  output logic                  pc_we,
  output logic                  rf_we,
  output logic                  csr_commit,
  output logic                  trap_take,
  output logic                  trap_ret,
  output logic                  halted,
  output logic                  bus_err,
  output logic [2:0]            state,
  output logic [DATA_WIDTH-1:0] cycle_cnt,
  output logic [DATA_WIDTH-1:0] instret_cnt
);

  localparam logic [2:0] S_BOOT   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
  localparam logic [2:0] S_ERROR  = 3'd6;

  localparam logic [7:0]            LP_TIMEOUT = 8'(TIMEOUT);
  localparam logic [DATA_WIDTH-1:0] LP_ONE     = DATA_WIDTH'(1);

  logic [2:0]            r_state;
  logic [2:0]            w_state_next;
  logic [7:0]            r_wait_cnt;
  logic                  w_wait_hit;
  logic [DATA_WIDTH-1:0] r_cycle_cnt;
  logic [DATA_WIDTH-1:0] r_instret_cnt;

  // This cycle would be the TIMEOUT-th cycle spent waiting; a handshake now still wins.
  assign w_wait_hit = (r_wait_cnt + 8'd1) == LP_TIMEOUT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_BOOT:   w_state_next = S_FETCH;
      S_FETCH: begin
        if (imem_valid) begin
          w_state_next = S_DECODE;
        end else if (w_wait_hit) begin
          w_state_next = S_ERROR;
        end
      end
      S_DECODE: begin
        if (dec_ebreak) begin
          w_state_next = S_HALT;
        end else if (dec_load || dec_mem_wen) begin
          w_state_next = S_MEM;
        end else begin
          w_state_next = S_WB;
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          w_state_next = S_WB;
        end else if (w_wait_hit) begin
          w_state_next = S_ERROR;
        end
      end
      S_WB:     w_state_next = S_FETCH;
      S_HALT:   w_state_next = S_HALT;
      S_ERROR:  w_state_next = S_ERROR;
      default:  w_state_next = S_ERROR;
    endcase
  end

  always_comb begin
    imem_req   = 1'b0;
    ir_we      = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    pc_we      = 1'b0;
    rf_we      = 1'b0;
    csr_commit = 1'b0;
    trap_take  = 1'b0;
    trap_ret   = 1'b0;
    halted     = 1'b0;
    bus_err    = 1'b0;
    case (r_state)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_valid;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = dec_mem_wen;
      end
      S_WB: begin
        pc_we      = 1'b1;
        rf_we      = dec_rf_we & ~dec_mem_wen;
        csr_commit = dec_csr;
        trap_take  = dec_ecall;
        trap_ret   = dec_mret & ~dec_ecall;
      end
      S_HALT:  halted  = 1'b1;
      S_ERROR: bus_err = 1'b1;
      default: ;
    endcase
  end

  // Any state change restarts the wait count, so each FETCH/MEM visit starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= 8'd0;
    end else if (w_state_next != r_state) begin
      r_wait_cnt <= 8'd0;
    end else if ((r_state == S_FETCH) || (r_state == S_MEM)) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + LP_ONE;
      if (r_state == S_WB) begin
        r_instret_cnt <= r_instret_cnt + LP_ONE;
      end
    end
  end

  assign state       = r_state;
  assign cycle_cnt   = r_cycle_cnt;
  assign instret_cnt = r_instret_cnt;

endmodule

// File: tb/tb_ysyx_22040729_core_sequencer.sv
// tb/tb_ysyx_22040729_core_sequencer.sv - randomized transaction-level check of the core sequencer
module tb_ysyx_22040729_core_sequencer;

  localparam int TO = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          imem_valid = 1'b0;
  logic          dec_rf_we = 1'b0;
  logic          dec_mem_wen = 1'b0;
  logic          dec_load = 1'b0;
  logic          dec_csr = 1'b0;
  logic          dec_ecall = 1'b0;
  logic          dec_mret = 1'b0;
  logic          dec_ebreak = 1'b0;
  logic          dmem_ack = 1'b0;
  logic          imem_req, ir_we, dmem_req, dmem_we, pc_we, rf_we;
  logic          csr_commit, trap_take, trap_ret, halted, bus_err;
  logic [2:0]    state;
  logic [DW-1:0] cycle_cnt, instret_cnt;
  logic [13:0]   w_obs;

  int n_tests = 0;
  int n_fail  = 0;
  int m_cyc   = 0;
  int m_ret   = 0;

  ysyx_22040729_core_sequencer #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_valid(imem_valid), .ir_we(ir_we),
    .dec_rf_we(dec_rf_we), .dec_mem_wen(dec_mem_wen), .dec_load(dec_load),
    .dec_csr(dec_csr), .dec_ecall(dec_ecall), .dec_mret(dec_mret), .dec_ebreak(dec_ebreak),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .pc_we(pc_we), .rf_we(rf_we), .csr_commit(csr_commit),
    .trap_take(trap_take), .trap_ret(trap_ret), .halted(halted), .bus_err(bus_err),
    .state(state), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  assign w_obs = {state, imem_req, ir_we, dmem_req, dmem_we, pc_we, rf_we,
                  csr_commit, trap_take, trap_ret, halted, bus_err};

  initial forever #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected outputs for a given state: request/status flags follow directly from the state.
  function automatic logic [13:0] vec(input logic [2:0] st, input logic irw, input logic dq,
                                      input logic dw, input logic pcw, input logic rfw,
                                      input logic csr, input logic tt, input logic tr);
    return {st, st == 3'd1, irw, dq, dw, pcw, rfw, csr, tt, tr, st == 3'd5, st == 3'd6};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic tick();
    @(negedge clk);
    if (rst_n) m_cyc++;
  endtask

  task automatic check_all(input string tag, input logic [13:0] exp);
    check(tag, 64'(w_obs), 64'(exp));
    check({tag, "_cyc"}, 64'(cycle_cnt), 64'(m_cyc % 256));
    check({tag, "_ret"}, 64'(instret_cnt), 64'(m_ret % 256));
  endtask

  task automatic scramble_dec();
    {dec_rf_we, dec_mem_wen, dec_load, dec_csr, dec_ecall, dec_mret, dec_ebreak} = 7'($urandom);
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    imem_valid = 1'b0;
    dmem_ack = 1'b0;
    {dec_rf_we, dec_mem_wen, dec_load, dec_csr, dec_ecall, dec_mret, dec_ebreak} = 7'd0;
    m_cyc = 0;
    m_ret = 0;
    #1;
    check("rst_outs", 64'(w_obs), 64'd0);
    check("rst_cyc", 64'(cycle_cnt), 64'd0);
    check("rst_ret", 64'(instret_cnt), 64'd0);
    repeat (2) tick();
    tick();
    rst_n = 1'b1;
    m_cyc = 0;
    #1 check_all("boot", vec(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic terminal(input logic [2:0] st, input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      imem_valid = rb();
      dmem_ack = rb();
      scramble_dec();
      #1 check_all(tag, vec(st, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    end
  endtask

  // One instruction: fetch data arrives on fetch cycle f, data ack on mem cycle m;
  // d = {rf_we, mem_wen, load, csr, ecall, mret, ebreak}.
  task automatic run_instr(input int f, input int m, input logic [6:0] d, output bit term);
    logic rfw, mw, ld, csr, ec, mr, eb;
    {rfw, mw, ld, csr, ec, mr, eb} = d;
    term = 1'b0;
    for (int c = 1; c <= TO; c++) begin
      tick();
      imem_valid = (c == f);
      dmem_ack = rb();
      scramble_dec();
      #1 check_all("fetch", vec(3'd1, c == f, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      if (c == f) break;
      if (c == TO) begin
        terminal(3'd6, "fetch_timeout", 3);
        term = 1'b1;
        return;
      end
    end
    tick();
    {dec_rf_we, dec_mem_wen, dec_load, dec_csr, dec_ecall, dec_mret, dec_ebreak} = d;
    imem_valid = rb();
    dmem_ack = rb();
    #1 check_all("decode", vec(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    if (eb) begin
      terminal(3'd5, "halt", 3);
      term = 1'b1;
      return;
    end
    if (ld || mw) begin
      for (int c = 1; c <= TO; c++) begin
        tick();
        dmem_ack = (c == m);
        imem_valid = rb();
        #1 check_all("mem", vec(3'd3, 1'b0, 1'b1, mw, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        if (c == m) break;
        if (c == TO) begin
          terminal(3'd6, "mem_timeout", 3);
          term = 1'b1;
          return;
        end
      end
    end
    tick();
    imem_valid = rb();
    dmem_ack = rb();
    #1 check_all("wb", vec(3'd4, 1'b0, 1'b0, 1'b0, 1'b1, rfw & ~mw, csr, ec, mr & ~ec));
    m_ret++;
  endtask

  initial begin
    bit t;
    logic [6:0] d;
    do_reset();

    run_instr(3, 1, 7'b1000000, t);        // add, fetch data two cycles after request
    run_instr(1, 4, 7'b0100000, t);        // store, ack on 4th mem cycle
    run_instr(2, 1, 7'b1010000, t);        // load, ack immediately
    run_instr(1, 1, 7'b0001100, t);        // ecall
    run_instr(1, 1, 7'b0001010, t);        // mret
    run_instr(1, 1, 7'b1001110, t);        // ecall+mret together: trap entry wins
    run_instr(TO + 1, 1, 7'b1000000, t);   // never valid -> bus error
    check("timeout_term", 64'(t), 64'd1);

    do_reset();
    run_instr(TO, 1, 7'b1000000, t);       // valid on the last allowed cycle
    run_instr(1, TO, 7'b1010000, t);       // ack on the last allowed mem cycle
    check("edge_no_err", 64'(t), 64'd0);
    run_instr(1, TO + 1, 7'b0100000, t);   // ack never comes -> bus error
    check("mem_timeout_term", 64'(t), 64'd1);

    do_reset();
    run_instr(2, 1, 7'b1000001, t);        // ebreak
    terminal(3'd5, "halt_wrap", 260);      // cycle counter keeps running and wraps

    do_reset();
    tick();
    imem_valid = 1'b0;
    #1 check_all("pre_rst_fetch", vec(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    rst_n = 1'b0;
    #1 check("async_rst_fetch", 64'(w_obs), 64'd0);

    do_reset();
    run_instr(1, 1, 7'b1000000, t);
    tick();
    imem_valid = 1'b1;
    #1 check_all("fetch2", vec(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick();
    imem_valid = 1'b0;
    {dec_rf_we, dec_mem_wen, dec_load, dec_csr, dec_ecall, dec_mret, dec_ebreak} = 7'b1010000;
    #1 check_all("decode2", vec(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick();
    dmem_ack = 1'b0;
    #1 check_all("mem2", vec(3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    rst_n = 1'b0;
    #1 check("async_rst_mem", 64'(w_obs), 64'd0);
    check("async_rst_mem_ret", 64'(instret_cnt), 64'd0);

    // long error-free run so the retired-instruction counter wraps
    do_reset();
    for (int i = 0; i < 300; i++) begin
      d = 7'($urandom) & 7'b1111110;
      run_instr($urandom_range(1, TO), $urandom_range(1, TO), d, t);
    end

    for (int s = 0; s < 30; s++) begin
      do_reset();
      for (int i = 0; i < 15; i++) begin
        d = 7'($urandom) & 7'b1111110;
        if ($urandom_range(0, 15) == 0) d[0] = 1'b1;
        run_instr($urandom_range(1, TO + 1), $urandom_range(1, TO + 1), d, t);
        if (t) break;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
